// File: rtl/fetch_stage_pkg.sv
// Shared constants for the fetch stage: reset PC, NOP encoding, opcodes and field slices.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [5:0]  OP_J             = 6'b00_0010;

    // Instruction field positions
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int JIDX_MSB   = 25;
    localparam int JIDX_LSB   = 0;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid, with stall > flush > capture priority.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc_plus4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;
    logic        r_valid;

    // Stall holds everything; a flush inserts a NOP bubble but still tracks PC+4.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= 32'h0000_0000;
            r_valid    <= 1'b0;
        end else if (i_stall) begin
            r_instr    <= r_instr;
            r_pc_plus4 <= r_pc_plus4;
            r_valid    <= r_valid;
        end else if (i_flush) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= i_pc_plus4;
            r_valid    <= 1'b0;
        end else begin
            r_instr    <= i_instr;
            r_pc_plus4 <= i_pc_plus4;
            r_valid    <= 1'b1;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        branch_taken_d,
    input  logic [31:0] branch_target_d,
    input  logic        jump_d,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0] r_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_jump_target;
    logic [31:0] w_branch_target;
    logic [31:0] w_next_pc;
    logic        w_redirect;
    logic        w_pc_load;

    // A bubble or a stalled decode slot must never steer the PC.
    assign w_redirect      = valid_d & ~stall_d & (jump_d | branch_taken_d);
    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_jump_target   = {pc_plus4_d[31:28], instr_d[JIDX_MSB:JIDX_LSB], 2'b00};
    assign w_branch_target = branch_target_d & ~32'h0000_0003;
    assign w_pc_load       = w_redirect | ~stall_f;

    // Next-PC select: jump beats branch beats sequential; only a live redirect leaves the sequential path.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (w_redirect) begin
            if (jump_d) begin
                w_next_pc = w_jump_target;
            end else begin
                w_next_pc = w_branch_target;
            end
        end
    end

    // PC register; a redirect overrides a fetch stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC_ALIGNED;
        end else if (w_pc_load) begin
            r_pc <= w_next_pc;
        end
    end

    assign pc_f      = r_pc;
    assign imem_addr = r_pc;

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .i_stall    (stall_d),
        .i_flush    (flush_d | w_redirect),
        .i_instr    (imem_rdata),
        .i_pc_plus4 (w_pc_plus4),
        .o_instr    (instr_d),
        .o_pc_plus4 (pc_plus4_d),
        .o_valid    (valid_d)
    );

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core. It owns the program counter, drives the Harvard instruction-memory address, and registers the fetched word for the decode stage, whose main decoder consumes `instr_d[31:5:26]`. It also applies decode-stage redirects (taken branch, jump), hazard stalls and flushes, inserting bubbles as NOPs.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `imem_addr`  out  32  instruction-memory byte address, equal to `pc_f` (combinational).
- `imem_rdata`  in  32  instruction word; combinational read of `imem_addr`.
- `stall_f`  in  1  hazard unit: hold the PC.
- `stall_d`  in  1  hazard unit: hold the IF/ID register.
- `flush_d`  in  1  hazard unit: bubble the IF/ID register.
- `branch_taken_d`  in  1  decode: branch in decode resolved taken.
- `branch_target_d`  in  32  decode: branch target byte address.
- `jump_d`  in  1  decode: main-decoder jump flag for `instr_d`.
- `pc_f`  out  32  current fetch PC.
- `instr_d`  out  32  registered instruction to decode.
- `pc_plus4_d`  out  32  registered PC+4 of `instr_d`.
- `valid_d`  out  1  `instr_d` is a real instruction, not a bubble.

## Operation
- `redirect = valid_d & ~stall_d & (jump_d | branch_taken_d)`.
  - A stalled or bubbled decode slot never redirects.
- Jump target is formed here: `{pc_plus4_d[31:28], instr_d[25:0], 2'b00}`.
- Next-PC priority:
  - `jump_d`: jump target.
  - Otherwise `branch_taken_d`: `{branch_target_d[31:2], 2'b00}`.
  - Otherwise `pc_f + 4`, mod 2^32 (wraps from 32'hFFFF_FFFC to 0).
- PC register:
  - Loads next-PC when `redirect | ~stall_f`; otherwise holds.
  - A redirect overrides `stall_f`.
  - `pc_f[1:0]` is always 2'b00.
- IF/ID register, in priority order:
  1. `stall_d`: hold all fields, even if `flush_d` or a redirect condition is present.
  2. `flush_d | redirect`: `instr_d` = 32'h0000_0000 (NOP), `valid_d` = 0, `pc_plus4_d` = `pc_f + 4`.
  3. Otherwise: capture `imem_rdata`, `pc_f + 4`, and `valid_d` = 1.
- Reset (asynchronous, any time, including mid-stall or mid-redirect):
  - `pc_f` = `RESET_PC`; `instr_d` = 0; `pc_plus4_d` = 0; `valid_d` = 0.
  - Outputs are valid immediately on assertion; the first fetch occurs from `RESET_PC` on the first edge after release.

## Timing
- Fetch latency: the word at `pc_f` in cycle N appears on `instr_d` in cycle N+1.
- Redirect penalty: exactly one bubble.
  - The wrong-path word fetched in the redirect cycle is flushed.
  - The target is on `pc_f` in the next cycle and on `instr_d` one cycle later.
- Stall: with `stall_f = stall_d = 1` for K cycles, `pc_f` and `instr_d` are frozen for K cycles; fetch resumes on the first edge after release.
- `imem_addr` changes only on `clk` edges or reset; no combinational path from inputs to `imem_addr`.
- Combinational paths `jump_d` / `branch_taken_d` / `branch_target_d` -> PC D-input are permitted.

## Structure
- Shared core package holds:
  - `RESET_PC` default.
  - NOP encoding 32'h0000_0000.
  - Jump opcode 6'b00_0010, used by benches to build stimulus.
  - Instruction field slice constants (opcode [31:26], jump index [25:0]).
- One natural sub-module: `if_id_reg`, holding the instruction, PC+4 and valid registers with stall/flush/async-reset priority.
- PC register and next-PC mux stay in the top.

## Test plan
- Reset, then release with `RESET_PC`=0 and sequential memory -> `pc_f` = 0,4,8,12 on successive cycles; `instr_d` lags by one cycle; `valid_d` rises on the first edge.
- `jump_d`=1 with `instr_d`=32'h0800_0040 and `pc_plus4_d`=32'h0000_0014 -> next `pc_f`=32'h0000_0100; the following `instr_d` is 0 with `valid_d`=0.
- `branch_taken_d`=1, `branch_target_d`=32'h0000_0203 -> `pc_f`=32'h0000_0200; one bubble.
- `stall_f`=`stall_d`=1 for 3 cycles with `branch_taken_d`=1 -> no redirect; `pc_f`/`instr_d` held for 3 cycles, then normal fetch resumes.
- `flush_d`=1 and `stall_d`=1 together -> IF/ID held. `flush_d` alone -> `instr_d`=0, `valid_d`=0, PC still advances by 4.
- Async reset asserted mid-cycle during a redirect -> outputs take reset values immediately with no clock edge; `pc_f`=0xFFFF_FFFC sequential fetch wraps to 0.
